// File: rtl/offset_calibrator.sv
// DC-offset corrector: saturating add of a stored offset onto every sample, with an
// on-request calibration that averages 2^LOG2_SAMPLES raw samples and stores -mean.
module offset_calibrator #(
  parameter int N            = 8,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic [N-1:0] Data,
  input  logic         Data_Valid,
  input  logic         Calibrate,
  input  logic         Load,
  input  logic [N-1:0] Offset_In,
  output logic [N-1:0] Output,
  output logic         Output_Valid,
  output logic [N-1:0] Offset,
  output logic         Busy,
  output logic         Done
);

  localparam int ACC_W = N + LOG2_SAMPLES;
  localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_SAMPLES) - 1);
  localparam logic signed [N-1:0] MAX_S = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic        [CNT_W-1:0]  cnt, cnt_nxt;
  logic signed [N-1:0]      off_p1, off_nxt;
  logic signed [N-1:0]      data_p0;
  logic signed [N-1:0]      out_p1;
  logic                     vld_p1;

  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
    logic signed [N:0] sum;
    sum = {a[N-1], a} + {b[N-1], b};
    case (sum[N:N-1])
      2'b01:   sat_add = MAX_S;
      2'b10:   sat_add = MIN_S;
      default: sat_add = sum[N-1:0];
    endcase
  endfunction

  // Floor mean via arithmetic shift; -MIN has no N-bit representation so it clips to MAX.
  function automatic logic signed [N-1:0] neg_mean_sat(input logic signed [ACC_W-1:0] a);
    logic signed [N-1:0] mean;
    mean = N'(a >>> LOG2_SAMPLES);
    if (mean == MIN_S) neg_mean_sat = MAX_S;
    else               neg_mean_sat = -mean;
  endfunction

  assign data_p0 = Data;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      off_p1 <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      off_p1 <= off_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    off_nxt   = off_p1;
    case (state)
      IDLE: begin
        if (Calibrate) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end else if (Load) begin
          off_nxt = Offset_In;
        end
      end
      ACCUM: begin
        if (Data_Valid) begin
          acc_nxt = acc + ACC_W'(data_p0);
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        off_nxt   = neg_mean_sat(acc);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: corrected sample register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= Data_Valid;
      if (Data_Valid) out_p1 <= sat_add(data_p0, off_p1);
    end
  end

  assign Output       = out_p1;
  assign Output_Valid = vld_p1;
  assign Offset       = off_p1;
  assign Busy         = (state != IDLE);
  assign Done         = (state == UPDATE);

endmodule
